// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave). One request may be outstanding.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [15:0]       imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// delivers returned words to the Fetch/Decode register, buffers a word that
// arrives while decode is stalled, and redirects on flush.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// fetch_count / stall_count performance counters.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  imem,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         flush_target,
    output logic [15:0]               instruction_out,
    output logic                      valid_out,
    output logic [ADDR_W-1:0]         pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]               fetch_count,
    output logic [15:0]               stall_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_req_en;      // low only between reset and the first edge
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;        // address of the outstanding request
    logic              r_drop;        // next response belongs to a flushed path
    logic [15:0]       r_hold_data;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [15:0]       r_instr;
    logic              r_valid;
    logic [ADDR_W-1:0] r_pc_out;

    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_drop_next;
    logic [15:0]       w_hold_data_next;
    logic [ADDR_W-1:0] w_hold_pc_next;
    logic [15:0]       w_instr_next;
    logic              w_valid_next;
    logic [ADDR_W-1:0] w_pc_out_next;
    logic              w_deliver;

    logic              w_req_valid;
    logic              w_accept;
    logic              w_freeze;
    logic              w_can_load;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_accept   = w_req_valid & imem.imem_req_ready;
    assign w_freeze   = stall & r_valid;
    assign w_can_load = ~w_freeze;
    assign w_pc_inc   = r_pc + ADDR_W'(PC_STEP);   // wraps modulo 2^ADDR_W

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush and drop both turn a response into a discard
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (flush || r_drop || w_can_load) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush || !stall) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Output logic: request only from FETCH, and never before the first edge
    always_comb begin
        w_req_valid         = r_req_en && (r_state == S_FETCH);
        imem.imem_req_valid = w_req_valid;
        imem.imem_addr      = r_pc;
    end

    // Datapath next values: PC, outstanding address, drop flag, hold buffer, outputs
    always_comb begin
        w_pc_next        = r_pc;
        w_addr_next      = r_addr;
        w_drop_next      = r_drop;
        w_hold_data_next = r_hold_data;
        w_hold_pc_next   = r_hold_pc;
        w_instr_next     = r_instr;
        w_valid_next     = r_valid;
        w_pc_out_next    = r_pc_out;
        w_deliver        = 1'b0;

        // Unless decode is holding a valid word, a cycle without delivery is a bubble
        if (!w_freeze) begin
            w_valid_next = 1'b0;
            w_instr_next = 16'h0000;
        end

        if (flush) begin
            w_pc_next        = flush_target;
            w_valid_next     = 1'b0;
            w_instr_next     = 16'h0000;
            w_hold_data_next = 16'h0000;
            w_hold_pc_next   = '0;
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        w_addr_next = r_pc;
                    end
                    w_drop_next = w_accept;
                end
                S_WAIT:  w_drop_next = ~imem.imem_rsp_valid;
                default: w_drop_next = 1'b0;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        w_addr_next = r_pc;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (r_drop) begin
                            w_drop_next = 1'b0;
                        end else if (w_can_load) begin
                            w_instr_next  = imem.imem_rsp_data;
                            w_pc_out_next = r_addr;
                            w_valid_next  = 1'b1;
                            w_pc_next     = w_pc_inc;
                            w_deliver     = 1'b1;
                        end else begin
                            w_hold_data_next = imem.imem_rsp_data;
                            w_hold_pc_next   = r_addr;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_instr_next     = r_hold_data;
                        w_pc_out_next    = r_hold_pc;
                        w_valid_next     = 1'b1;
                        w_pc_next        = w_pc_inc;
                        w_deliver        = 1'b1;
                        w_hold_data_next = 16'h0000;
                        w_hold_pc_next   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_en    <= 1'b0;
            r_pc        <= RESET_PC;
            r_addr      <= '0;
            r_drop      <= 1'b0;
            r_hold_data <= 16'h0000;
            r_hold_pc   <= '0;
            r_instr     <= 16'h0000;
            r_valid     <= 1'b0;
            r_pc_out    <= '0;
        end else begin
            r_req_en    <= 1'b1;
            r_pc        <= w_pc_next;
            r_addr      <= w_addr_next;
            r_drop      <= w_drop_next;
            r_hold_data <= w_hold_data_next;
            r_hold_pc   <= w_hold_pc_next;
            r_instr     <= w_instr_next;
            r_valid     <= w_valid_next;
            r_pc_out    <= w_pc_out_next;
        end
    end

    assign instruction_out = r_instr;
    assign valid_out       = r_valid;
    assign pc_out          = r_pc_out;

`ifdef FETCH_PERF_CNT_EN
    // Counter 0 counts delivered instructions, counter 1 counts stalled cycles
    logic [1:0]       w_cnt_inc;
    logic [1:0][15:0] w_cnt_val;

    assign w_cnt_inc = {w_freeze, w_deliver};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [15:0] r_cnt;

            // Saturating event counter
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= 16'h0000;
                end else if (w_cnt_inc[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign w_cnt_val[gi] = r_cnt;
        end
    endgenerate

    assign fetch_count = w_cnt_val[0];
    assign stall_count = w_cnt_val[1];
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. A default-parameter instance
// covers fetch, stall/hold, flush and reset scenarios; a second instance with
// RESET_PC=16'hFFFF covers PC wrap-around.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;

    logic        stall, flush;
    logic [15:0] flush_target;
    logic [15:0] instruction_out;
    logic        valid_out;
    logic [15:0] pc_out;

    logic        stall_w, flush_w;
    logic [15:0] flush_target_w;
    logic [15:0] instruction_out_w;
    logic        valid_out_w;
    logic [15:0] pc_out_w;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, stall_count;
    logic [15:0] fetch_count_w, stall_count_w;
`endif

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit_if #(.ADDR_W(16)) bus ();
    instruction_fetch_unit_if #(.ADDR_W(16)) bus_w ();

    instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .PC_STEP(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus),
        .stall           (stall),
        .flush           (flush),
        .flush_target    (flush_target),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .pc_out          (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF), .PC_STEP(1)) dut_w (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus_w),
        .stall           (stall_w),
        .flush           (flush_w),
        .flush_target    (flush_target_w),
        .instruction_out (instruction_out_w),
        .valid_out       (valid_out_w),
        .pc_out          (pc_out_w)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count_w),
        .stall_count     (stall_count_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per memory response transaction
    always @(posedge clk) begin
        if (reset && bus.imem_rsp_valid)
            $display("[%0t] rsp  data=%h", $time, bus.imem_rsp_data);
        if (reset && bus_w.imem_rsp_valid)
            $display("[%0t] rspw data=%h", $time, bus_w.imem_rsp_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: one accepted request followed by a one-cycle response
    task automatic do_fetch(input logic [15:0] data);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%h want=0", bus.imem_req_valid); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got=%h want=0", valid_out); end
        checks++; if (instruction_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h want=0000", instruction_out); end
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out got=%h want=0000", pc_out); end
        reset = 1'b1;
        tick();
        checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_edge_req_valid got=%h want=1", bus.imem_req_valid); end
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr got=%h want=0000", bus.imem_addr); end
    endtask

    task automatic test_basic_fetch();
        logic [15:0] exp_instr;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_instr = 16'hA001 + 16'(i);
            tick();   // request accepted
            checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req_valid[%0d] got=%h want=0", i, bus.imem_req_valid); end
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_bubble[%0d] got=%h want=0", i, valid_out); end
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = exp_instr;
            tick();   // response delivered
            bus.imem_rsp_valid = 1'b0;
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%h want=1", i, valid_out); end
            checks++; if (instruction_out !== exp_instr) begin errors++; $display("FAIL basic_instr[%0d] got=%h want=%h", i, instruction_out, exp_instr); end
            checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL basic_pc_out[%0d] got=%h want=%h", i, pc_out, 16'(i)); end
            checks++; if (bus.imem_addr !== 16'(i + 1)) begin errors++; $display("FAIL basic_next_addr[%0d] got=%h want=%h", i, bus.imem_addr, 16'(i + 1)); end
        end
        bus.imem_req_ready = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_no_dup got=%h want=0", valid_out); end
        checks++; if (instruction_out !== 16'h0000) begin errors++; $display("FAIL basic_nop got=%h want=0000", instruction_out); end
        checks++; if (pc_out !== 16'h0002) begin errors++; $display("FAIL basic_pc_hold got=%h want=0002", pc_out); end
    endtask

    task automatic test_stall_hold();
        do_fetch(16'h1234);   // pc 3 delivered
        checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL hold_pre_pc got=%h want=0003", pc_out); end
        stall = 1'b1;
        bus.imem_req_ready = 1'b1;
        tick();               // request for 4 accepted, stall cycle 1
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 16'hBEEF;
        tick();               // response buffered, stall cycle 2
        bus.imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%h want=1", i, valid_out); end
            checks++; if (instruction_out !== 16'h1234) begin errors++; $display("FAIL hold_instr[%0d] got=%h want=1234", i, instruction_out); end
            checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL hold_pc[%0d] got=%h want=0003", i, pc_out); end
            checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_req_valid[%0d] got=%h want=0", i, bus.imem_req_valid); end
            tick();           // stall cycles 3..5
        end
        stall = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL hold_release_valid got=%h want=1", valid_out); end
        checks++; if (instruction_out !== 16'hBEEF) begin errors++; $display("FAIL hold_release_instr got=%h want=beef", instruction_out); end
        checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL hold_release_pc got=%h want=0004", pc_out); end
        checks++; if (bus.imem_addr !== 16'h0005) begin errors++; $display("FAIL hold_next_addr got=%h want=0005", bus.imem_addr); end
    endtask

    task automatic test_flush_outstanding();
        bus.imem_req_ready = 1'b1;
        tick();               // request for 5 outstanding
        bus.imem_req_ready = 1'b0;
        flush        = 1'b1;
        flush_target = 16'h0040;
        tick();
        flush = 1'b0;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flushw_still_wait got=%h want=0", bus.imem_req_valid); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 16'hDEAD;
        tick();               // stale response dropped
        bus.imem_rsp_valid = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flushw_dropped got=%h want=0", valid_out); end
        checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL flushw_addr got=%h want=0040", bus.imem_addr); end
        do_fetch(16'h4040);
        checks++; if (pc_out !== 16'h0040) begin errors++; $display("FAIL flushw_pc_out got=%h want=0040", pc_out); end
        checks++; if (instruction_out !== 16'h4040) begin errors++; $display("FAIL flushw_instr got=%h want=4040", instruction_out); end
    endtask

    task automatic test_flush_rsp_stall();
        stall = 1'b1;
        bus.imem_req_ready = 1'b1;
        tick();               // request for 0x41 outstanding, outputs frozen
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 16'h5555;
        flush        = 1'b1;
        flush_target = 16'h0080;
        tick();
        flush = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        stall = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flushr_valid got=%h want=0", valid_out); end
        checks++; if (instruction_out !== 16'h0000) begin errors++; $display("FAIL flushr_instr got=%h want=0000", instruction_out); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL flushr_req_valid got=%h want=1", bus.imem_req_valid); end
        checks++; if (bus.imem_addr !== 16'h0080) begin errors++; $display("FAIL flushr_addr got=%h want=0080", bus.imem_addr); end
        do_fetch(16'h8080);
        checks++; if (pc_out !== 16'h0080) begin errors++; $display("FAIL flushr_pc_out got=%h want=0080", pc_out); end
    endtask

    task automatic test_flush_fetch();
        flush        = 1'b1;
        flush_target = 16'h0100;
        tick();               // not accepted: redirect in place
        flush = 1'b0;
        checks++; if (bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL flushf_addr got=%h want=0100", bus.imem_addr); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flushf_valid got=%h want=0", valid_out); end
    endtask

    task automatic test_reset_mid();
        bus.imem_req_ready = 1'b1;
        tick();               // request for 0x100 outstanding
        bus.imem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid got=%h want=0", bus.imem_req_valid); end
        tick();
        reset = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 16'h7777;
        tick();
        bus.imem_rsp_valid = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%h want=0", valid_out); end
        checks++; if (instruction_out !== 16'h0000) begin errors++; $display("FAIL rstmid_instr got=%h want=0000", instruction_out); end
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_addr got=%h want=0000", bus.imem_addr); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_req_again got=%h want=1", bus.imem_req_valid); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL perf_fetch_reset got=%0d want=0", fetch_count); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL perf_stall_reset got=%0d want=0", stall_count); end
        do_fetch(16'hC001);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b0;
        do_fetch(16'hC002);
        do_fetch(16'hC003);
        checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL perf_fetch_count got=%0d want=3", fetch_count); end
        checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL perf_stall_count got=%0d want=4", stall_count); end
    endtask
`endif

    task automatic test_wrap();
        bus_w.imem_req_ready = 1'b1;
        tick();
        bus_w.imem_req_ready = 1'b0;
        bus_w.imem_rsp_valid = 1'b1;
        bus_w.imem_rsp_data  = 16'hF00F;
        tick();
        bus_w.imem_rsp_valid = 1'b0;
        checks++; if (pc_out_w !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc_first got=%h want=ffff", pc_out_w); end
        checks++; if (valid_out_w !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%h want=1", valid_out_w); end
        checks++; if (bus_w.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr got=%h want=0000", bus_w.imem_addr); end
        bus_w.imem_req_ready = 1'b1;
        tick();
        bus_w.imem_req_ready = 1'b0;
        bus_w.imem_rsp_valid = 1'b1;
        bus_w.imem_rsp_data  = 16'h0F00;
        tick();
        bus_w.imem_rsp_valid = 1'b0;
        checks++; if (pc_out_w !== 16'h0000) begin errors++; $display("FAIL wrap_pc_second got=%h want=0000", pc_out_w); end
        checks++; if (instruction_out_w !== 16'h0F00) begin errors++; $display("FAIL wrap_instr got=%h want=0f00", instruction_out_w); end
    endtask

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        flush_target   = 16'h0000;
        stall_w        = 1'b0;
        flush_w        = 1'b0;
        flush_target_w = 16'h0000;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = 16'h0000;
        bus_w.imem_req_ready = 1'b0;
        bus_w.imem_rsp_valid = 1'b0;
        bus_w.imem_rsp_data  = 16'h0000;

        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_flush_outstanding();
        test_flush_rsp_stall();
        test_flush_fetch();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, setting the instruction address width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, setting the PC value loaded on reset.
REQ-003 The block SHALL have parameter PC_STEP, default 1, setting the PC increment per fetched instruction (word addressing).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_req_valid  output  1  fetch request valid toward instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_addr  output  ADDR_W  fetch address.
REQ-009 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-010 imem_rsp_data  input  16  returned instruction word.
REQ-011 stall  input  1  decode side cannot accept a new instruction.
REQ-012 flush  input  1  redirect fetch; discard all in-flight and held instructions.
REQ-013 flush_target  input  ADDR_W  new PC, sampled when flush=1.
REQ-014 instruction_out  output  16  instruction delivered to the Fetch/Decode pipeline register.
REQ-015 valid_out  output  1  instruction_out holds a real instruction; 0 means bubble.
REQ-016 pc_out  output  ADDR_W  address of instruction_out.

Function
REQ-017 The block SHALL implement the states FETCH (request issuing), WAIT (one request outstanding) and HOLD (response buffered during stall), with at most one request outstanding.
REQ-018 In FETCH, imem_req_valid=1 and imem_addr=PC; on imem_req_valid&imem_req_ready the block SHALL latch the address and go to WAIT.
REQ-019 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0, except in the cycle after a flush.
REQ-020 imem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-021 In WAIT, when imem_rsp_valid=1 and (stall=0 or valid_out=0), the block SHALL, on the next edge, load instruction_out=imem_rsp_data, pc_out=latched address and valid_out=1, advance PC by PC_STEP, and go to FETCH.
REQ-022 In WAIT, when imem_rsp_valid=1 and stall=1 and valid_out=1, the block SHALL capture the word and address into a hold buffer and go to HOLD.
REQ-023 In HOLD, on the first cycle with stall=0, the block SHALL move the hold buffer to the outputs with valid_out=1, advance PC, and go to FETCH.
REQ-024 While stall=1 and valid_out=1, instruction_out, pc_out and valid_out SHALL hold their values.
REQ-025 When stall=0 and no instruction is delivered in a cycle, the block SHALL set valid_out=0 and instruction_out=16'h0000 (NOP bubble) on the next edge; pc_out holds.
REQ-026 flush SHALL have priority over stall and over any response: on the next edge PC=flush_target, valid_out=0, instruction_out=0, and the hold buffer is cleared.
REQ-027 On flush in WAIT with no response that cycle, the block SHALL set a drop flag, stay in WAIT, discard the next response, clear the flag and go to FETCH.
REQ-028 On flush in WAIT coinciding with imem_rsp_valid, the block SHALL discard the response and go to FETCH.
REQ-029 On flush in FETCH coinciding with an accepted request, the block SHALL go to WAIT with the drop flag set; on flush in FETCH without acceptance, it SHALL stay in FETCH and request flush_target next cycle.
REQ-030 On flush in HOLD, the block SHALL go to FETCH.
REQ-031 PC arithmetic SHALL be modulo 2^ADDR_W, with wrap-around from the top address to 0.

Reset
REQ-032 While reset=0, the block SHALL set state=FETCH, PC=RESET_PC, drop flag=0, hold buffer cleared, imem_req_valid=0, instruction_out=0, valid_out=0 and pc_out=0.
REQ-033 After reset deasserts, imem_req_valid SHALL rise at the first rising clk edge, and a reset asserted mid-transaction SHALL abandon any outstanding request without later consuming its response.

Configuration
REQ-034 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_count (16 bits) and stall_count (16 bits), both reset to 0 and saturating at 16'hFFFF.
REQ-035 fetch_count SHALL increment per valid_out 0->1 load or new-instruction load; stall_count SHALL increment per cycle with stall=1 and valid_out=1.
REQ-036 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then memory ready=1 with 1-cycle response at addresses 0,1,2 returning 16'hA001/A002/A003 -> valid_out pulses with pc_out 0,1,2 in order, no duplicates.
REQ-038 Stall=1 for 5 cycles while response 16'hBEEF returns -> enters HOLD, outputs frozen, then 16'hBEEF delivered on the first cycle after stall drops.
REQ-039 Flush to 16'h0040 while a request for 0x0005 is outstanding -> that response is dropped and the next delivered pc_out is 0x0040.
REQ-040 Flush and imem_rsp_valid in the same cycle, with stall=1 -> response discarded, valid_out=0 next cycle, next fetch address = flush_target.
REQ-041 With RESET_PC=16'hFFFF, fetch twice -> pc_out 0xFFFF then 0x0000.
REQ-042 With FETCH_PERF_CNT_EN defined, 3 fetches and 4 stalled cycles -> fetch_count=3, stall_count=4.
